// File: rtl/or_multi_pkg.sv
// Shared types and helpers for the or/and/intersect stimulus generator.
// Holds the FSM state encoding, default widths and the delay clamp used at start.
package or_multi_pkg;

    localparam int DLY_W_DEF   = 3;
    localparam int MAX_DLY_DEF = 7;
    localparam int CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        DONE
    } state_t;

    // Zero would put the strobe on the a-rise cycle, so it is lifted to one;
    // anything beyond the legal maximum is pinned to the maximum.
    function automatic int unsigned clamp_dly(input int unsigned dly, input int unsigned max_dly);
        if (dly == 0) begin
            return 1;
        end else if (dly > max_dly) begin
            return max_dly;
        end else begin
            return dly;
        end
    endfunction

endpackage

// File: rtl/or_multi_stim_gen_if.sv
// Request/config inputs and stimulus outputs of the generator, bundled as one port.
// master drives requests (test harness), slave is the generator itself.
// Optional macro OR_MULTI_STIM_ERR_INJ_EN adds err_inj_i / err_run_o.
interface or_multi_stim_gen_if
    import or_multi_pkg::*;
#(
    parameter int DLY_W = DLY_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic             start_i;
    logic [DLY_W-1:0] b_dly_i;
    logic [DLY_W-1:0] c_dly_i;
    logic             e_en_i;
    logic             a_o;
    logic             b_o;
    logic             c_o;
    logic             d_o;
    logic             e_o;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] run_cnt_o;
`ifdef OR_MULTI_STIM_ERR_INJ_EN
    logic             err_inj_i;
    logic             err_run_o;

    modport master (
        output start_i, b_dly_i, c_dly_i, e_en_i, err_inj_i,
        input  a_o, b_o, c_o, d_o, e_o, busy_o, done_o, run_cnt_o, err_run_o
    );

    modport slave (
        input  start_i, b_dly_i, c_dly_i, e_en_i, err_inj_i,
        output a_o, b_o, c_o, d_o, e_o, busy_o, done_o, run_cnt_o, err_run_o
    );
`else
    modport master (
        output start_i, b_dly_i, c_dly_i, e_en_i,
        input  a_o, b_o, c_o, d_o, e_o, busy_o, done_o, run_cnt_o
    );

    modport slave (
        input  start_i, b_dly_i, c_dly_i, e_en_i,
        output a_o, b_o, c_o, d_o, e_o, busy_o, done_o, run_cnt_o
    );
`endif

endinterface

// File: rtl/or_multi_pulse_tmr.sv
// Tick counter for one run. Tick 0 is the a-rise cycle; the b/c/d strobes are
// registered against the upcoming tick so they appear exactly on their tick.
// b_seen/d_seen stay set from the strobe cycle until the next load.
module or_multi_pulse_tmr #(
    parameter int MAX_DLY = 7,
    parameter int TICK_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              run_i,
    input  logic              b_mask_i,
    input  logic [TICK_W-1:0] b_dly_i,
    input  logic [TICK_W-1:0] c_dly_i,
    output logic              b_o,
    output logic              c_o,
    output logic              d_o,
    output logic              b_seen_o,
    output logic              d_seen_o,
    output logic              timeout_o
);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic              b_q, b_d;
    logic              c_q, c_d;
    logic              d_q, d_d;
    logic              b_seen_q, b_seen_d;
    logic              d_seen_q, d_seen_d;

    // Next tick and strobe decode; delays are already clamped to at least one.
    always_comb begin
        tick_d   = tick_q;
        b_d      = 1'b0;
        c_d      = 1'b0;
        d_d      = 1'b0;
        b_seen_d = b_seen_q;
        d_seen_d = d_seen_q;
        if (load_i) begin
            tick_d   = '0;
            b_seen_d = 1'b0;
            d_seen_d = 1'b0;
        end else if (run_i) begin
            tick_d   = tick_q + TICK_W'(1);
            b_d      = !b_mask_i && (tick_d == b_dly_i);
            c_d      = (tick_d == c_dly_i);
            d_d      = (tick_d == (c_dly_i + TICK_W'(1)));
            b_seen_d = b_seen_q | b_d;
            d_seen_d = d_seen_q | d_d;
        end
    end

    // Tick and strobe registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q   <= '0;
            b_q      <= 1'b0;
            c_q      <= 1'b0;
            d_q      <= 1'b0;
            b_seen_q <= 1'b0;
            d_seen_q <= 1'b0;
        end else begin
            tick_q   <= tick_d;
            b_q      <= b_d;
            c_q      <= c_d;
            d_q      <= d_d;
            b_seen_q <= b_seen_d;
            d_seen_q <= d_seen_d;
        end
    end

    assign b_o       = b_q;
    assign c_o       = c_q;
    assign d_o       = d_q;
    assign b_seen_o  = b_seen_q;
    assign d_seen_o  = d_seen_q;
    assign timeout_o = b_mask_i && (tick_q == TICK_W'(MAX_DLY + 2));

endmodule

// File: rtl/or_multi_stim_gen.sv
// Stimulus generator feeding the or/and/intersect sequence checker.
// Each run: ARM (a low), RUN (a high, b/c/d at programmed ticks), DONE (done pulse).
// Optional macro OR_MULTI_STIM_ERR_INJ_EN: err_inj suppresses b, the run times
// out at tick MAX_DLY+2 and err_run pulses alongside done.
module or_multi_stim_gen
    import or_multi_pkg::*;
#(
    parameter int DLY_W   = DLY_W_DEF,
    parameter int MAX_DLY = MAX_DLY_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    or_multi_stim_gen_if.slave  bus
);

    localparam int TICK_W = $clog2(MAX_DLY + 3);

    state_t            state_q;
    logic [TICK_W-1:0] b_dly_q;
    logic [TICK_W-1:0] c_dly_q;
    logic              e_en_q;
    logic              a_q;
    logic              e_q;
    logic              busy_q;
    logic              done_q;
    logic [CNT_W-1:0]  run_cnt_q;
    logic              b_mask;
    logic              b_seen;
    logic              d_seen;
    logic              timeout;
    logic              run_end;

`ifdef OR_MULTI_STIM_ERR_INJ_EN
    logic              err_inj_q;
    logic              err_run_q;
    assign b_mask         = err_inj_q;
    assign bus.err_run_o  = err_run_q;
`else
    assign b_mask = 1'b0;
`endif

    assign run_end = (state_q == RUN) && ((b_seen && d_seen) || timeout);

    or_multi_pulse_tmr #(
        .MAX_DLY (MAX_DLY),
        .TICK_W  (TICK_W)
    ) u_tmr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (state_q == ARM),
        .run_i     (state_q == RUN),
        .b_mask_i  (b_mask),
        .b_dly_i   (b_dly_q),
        .c_dly_i   (c_dly_q),
        .b_o       (bus.b_o),
        .c_o       (bus.c_o),
        .d_o       (bus.d_o),
        .b_seen_o  (b_seen),
        .d_seen_o  (d_seen),
        .timeout_o (timeout)
    );

    // Run sequencer with registered a/e/busy/done and the completed-run counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            b_dly_q   <= '0;
            c_dly_q   <= '0;
            e_en_q    <= 1'b0;
            a_q       <= 1'b0;
            e_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            run_cnt_q <= '0;
`ifdef OR_MULTI_STIM_ERR_INJ_EN
            err_inj_q <= 1'b0;
            err_run_q <= 1'b0;
`endif
        end else begin
            e_q    <= 1'b0;
            done_q <= 1'b0;
`ifdef OR_MULTI_STIM_ERR_INJ_EN
            err_run_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        b_dly_q <= TICK_W'(clamp_dly(32'(bus.b_dly_i), 32'(MAX_DLY)));
                        c_dly_q <= TICK_W'(clamp_dly(32'(bus.c_dly_i), 32'(MAX_DLY)));
                        e_en_q  <= bus.e_en_i;
`ifdef OR_MULTI_STIM_ERR_INJ_EN
                        err_inj_q <= bus.err_inj_i;
`endif
                        busy_q  <= 1'b1;
                        state_q <= ARM;
                    end
                end
                ARM: begin
                    a_q     <= 1'b1;
                    e_q     <= e_en_q;
                    state_q <= RUN;
                end
                RUN: begin
                    if (run_end) begin
                        a_q       <= 1'b0;
                        done_q    <= 1'b1;
                        run_cnt_q <= run_cnt_q + CNT_W'(1);
`ifdef OR_MULTI_STIM_ERR_INJ_EN
                        err_run_q <= err_inj_q;
`endif
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    a_q     <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.a_o       = a_q;
    assign bus.e_o       = e_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.run_cnt_o = run_cnt_q;

endmodule
